simd_addsub_pipe: RTL and testbench
===================================

Name: simd_addsub_pipe

Overview:
- Pipelined, multi-lane integer add/subtract unit for the vector execute stage of the SIMD AES datapath; successor to the scalar adder/subtractor.
- Processes LANES independent W-bit lanes, or one chained LANES*W-bit word, producing a result and N/Z/C/V flags.
- Two-stage valid/ready pipeline, full throughput, tag passthrough, sticky overflow status.

Parameters:
W, 32, lane width in bits (W >= 2)
LANES, 4, number of lanes (LANES >= 1)
TAG_W, 4, width of transaction tag carried alongside data

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input transaction valid
in_ready  out  1  unit can accept input
in_op  in  1  0 = add (A+B), 1 = subtract (A-B)
in_chain  in  1  0 = per-lane; 1 = lanes chained into one LANES*W-bit word, lane 0 least significant
in_tag  in  TAG_W  opaque tag
in_a  in  LANES*W  operand A, lane i = bits [i*W +: W]
in_b  in  LANES*W  operand B, same packing
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_r  out  LANES*W  result
out_n  out  LANES  per-lane negative flag
out_z  out  LANES  per-lane zero flag
out_c  out  LANES  per-lane carry (add) / borrow (sub) flag
out_v  out  LANES  per-lane signed-overflow flag
out_tag  out  TAG_W  tag of the result
clr_sticky  in  1  clear v_sticky
v_sticky  out  1  set when any accepted result has any V flag set

Behaviour:
- Reset (rst_n low, asynchronous): in both stages valid = 0; out_valid = 0; out_r, all flags, out_tag, v_sticky = 0. in_ready reads 1 after reset. Transactions in flight are discarded; none reappear after release.
- Stage S1 registers in_a, in_b, in_op, in_chain, in_tag on accept (in_valid && in_ready). Stage S2 (output register) holds the computed result and flags.
- Latency: accept at edge k -> out_valid high after edge k+1 when there is no stall. Throughput 1 transaction per cycle.
- Stall rule: advance = !out_valid || out_ready. in_ready = !s1_valid || advance; it is combinational from out_ready only.
- While out_valid && !out_ready: out_r, flags and out_tag hold stable. S1 holds. A third transaction is refused.
- Ordering: results emerge in accept order. Tags are never reordered or dropped.
- Arithmetic: subtract computed as A + ~B + 1.
  - Add: C = carry-out.
  - Subtract: C = borrow = (A < B unsigned) = ~carry-out.
  - N = result MSB. Z = (result == 0). V = signed overflow: for add, operands have the same sign and the result sign differs; for sub, operands have different signs and the result sign differs from A.
- Per-lane mode: each lane is independent and gets its own carry-in (op). No carry crosses lanes.
- Chained mode: carry/borrow ripples from lane i to lane i+1. Flags are computed on the full LANES*W word (N from the top MSB, Z over the whole word, C/V from the top lane) and replicated onto all LANES bits of each flag output.
- v_sticky: set when S2 loads a result with |out_v. clr_sticky clears it. Simultaneous set and clear: set wins. clr_sticky is ignored while rst_n is low.
- LANES = 1 with in_chain = 1 behaves identically to in_chain = 0.

Test Plan:
- W=32, LANES=4, per-lane sub, A lanes {30, 10, 1, 7FFFFFFF}, B lanes {10, 30, 1, FFFFFFFF} (lane 0 first) -> R = {00000014, FFFFFFEC, 00000000, 80000000}; N = {0,1,0,1}; Z = {0,0,1,0}; C = {0,1,0,1}; V = {0,0,0,1}; v_sticky = 1 on the following cycle.
- Per-lane add, A lanes {FFFFFFFF, 7FFFFFFF, 80000000, 5}, B lanes {1, 1, 80000000, 3} -> R = {0, 80000000, 0, 8}; Z = {1,0,1,0}; C = {1,0,1,0}; V = {0,1,1,0}; N = {0,1,0,0}.
- Chained add, A = 0x0..0_FFFFFFFF, B = 1 -> lane0 = 0, lane1 = 1, others 0; all flags 0 on every lane.
- Chained sub, A = 0, B = 1 -> every lane FFFFFFFF; N = C = 4'b1111; Z = V = 0.
- Backpressure: hold out_ready = 0, offer tags 1, 2, 3 back-to-back -> tag 1 on output, tag 2 in S1, in_ready = 0, tag 3 not accepted and held by the source. Raise out_ready -> tags 1, 2, 3 delivered on consecutive cycles with unchanged data.
- Reset mid-stream: two transactions in flight, pulse rst_n low between edges -> out_valid, in_ready state and v_sticky clear immediately; no stale result appears after release. Also: clr_sticky coincident with a V result -> v_sticky stays 1.

Source files
------------

// File: rtl/simd_addsub_pipe.sv
// rtl/simd_addsub_pipe.sv - two-stage multi-lane add/subtract unit with chained mode and sticky overflow
module simd_addsub_pipe #(
  parameter int W     = 32,
  parameter int LANES = 4,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_op,
  input  logic                 in_chain,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [LANES*W-1:0]   in_a,
  input  logic [LANES*W-1:0]   in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_r,
  output logic [LANES-1:0]     out_n,
  output logic [LANES-1:0]     out_z,
  output logic [LANES-1:0]     out_c,
  output logic [LANES-1:0]     out_v,
  output logic [TAG_W-1:0]     out_tag,
  input  logic                 clr_sticky,
  output logic                 v_sticky
);

  localparam int DW = LANES * W;

  logic             s1_valid_q;
  logic [DW-1:0]    s1_a_q, s1_b_q;
  logic             s1_op_q, s1_chain_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             out_valid_q;
  logic [DW-1:0]    r_q;
  logic [LANES-1:0] n_q, z_q, c_q, v_q;
  logic [TAG_W-1:0] tag_q;
  logic             sticky_q;

  logic             advance;
  logic             accept;
  logic             s2_load;

  logic [DW-1:0]    r_d;
  logic [LANES-1:0] n_d, z_d, c_d, v_d;
  logic             sticky_d;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || advance;
  assign accept   = in_valid && in_ready;
  assign s2_load  = advance && s1_valid_q;

  // Subtract is A + ~B + op; in chained mode only lane 0 sees op, higher lanes take the ripple.
  always_comb begin
    logic [LANES:0]   carry;
    logic [LANES-1:0] ln, lz, lc, lv;
    logic [DW-1:0]    bx;
    logic [W:0]       sum;
    logic             cin;
    logic             a_msb, bx_msb;
    carry    = '0;
    ln       = '0;
    lz       = '0;
    lc       = '0;
    lv       = '0;
    sum      = '0;
    cin      = 1'b0;
    a_msb    = 1'b0;
    bx_msb   = 1'b0;
    r_d      = '0;
    bx       = s1_op_q ? ~s1_b_q : s1_b_q;
    carry[0] = s1_op_q;
    for (int i = 0; i < LANES; i++) begin
      cin        = s1_chain_q ? carry[i] : s1_op_q;
      sum        = {1'b0, s1_a_q[i*W +: W]} + {1'b0, bx[i*W +: W]} + {{W{1'b0}}, cin};
      carry[i+1] = sum[W];
      r_d[i*W +: W] = sum[W-1:0];
      a_msb      = s1_a_q[i*W + W-1];
      bx_msb     = bx[i*W + W-1];
      ln[i]      = sum[W-1];
      lz[i]      = (sum[W-1:0] == '0);
      lc[i]      = sum[W] ^ s1_op_q;
      lv[i]      = (a_msb == bx_msb) && (sum[W-1] != a_msb);
    end
    if (s1_chain_q) begin
      n_d = {LANES{ln[LANES-1]}};
      z_d = {LANES{&lz}};
      c_d = {LANES{lc[LANES-1]}};
      v_d = {LANES{lv[LANES-1]}};
    end else begin
      n_d = ln;
      z_d = lz;
      c_d = lc;
      v_d = lv;
    end
  end

  // A fresh overflow outranks a same-cycle clear.
  always_comb begin
    sticky_d = sticky_q;
    if (s2_load && |v_d) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= 1'b0;
      s1_chain_q <= 1'b0;
      s1_tag_q   <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_a_q     <= in_a;
      s1_b_q     <= in_b;
      s1_op_q    <= in_op;
      s1_chain_q <= in_chain;
      s1_tag_q   <= in_tag;
    end else if (advance) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      r_q         <= '0;
      n_q         <= '0;
      z_q         <= '0;
      c_q         <= '0;
      v_q         <= '0;
      tag_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      if (advance) begin
        out_valid_q <= s1_valid_q;
      end
      if (s2_load) begin
        r_q   <= r_d;
        n_q   <= n_d;
        z_q   <= z_d;
        c_q   <= c_d;
        v_q   <= v_d;
        tag_q <= s1_tag_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = r_q;
  assign out_n     = n_q;
  assign out_z     = z_q;
  assign out_c     = c_q;
  assign out_v     = v_q;
  assign out_tag   = tag_q;
  assign v_sticky  = sticky_q;

endmodule

// File: tb/tb_simd_addsub_pipe.sv
// tb/tb_simd_addsub_pipe.sv - directed bench with arithmetic reference model and scoreboard
module tb_simd_addsub_pipe;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_op = 1'b0;
  logic         in_chain = 1'b0;
  logic [3:0]   in_tag = '0;
  logic [127:0] in_a = '0;
  logic [127:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_r;
  logic [3:0]   out_n, out_z, out_c, out_v, out_tag;
  logic         clr_sticky = 1'b0;
  logic         v_sticky;

  int checks = 0;
  int failures = 0;
  logic busy = 1'b0;

  typedef struct packed {
    logic [127:0] r;
    logic [3:0]   n, z, c, v, tag;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  simd_addsub_pipe #(.W(32), .LANES(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_chain(in_chain), .in_tag(in_tag), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_n(out_n),
    .out_z(out_z), .out_c(out_c), .out_v(out_v), .out_tag(out_tag),
    .clr_sticky(clr_sticky), .v_sticky(v_sticky)
  );

  function automatic exp_t model(input logic [127:0] a, input logic [127:0] b,
                                 input logic op, input logic chain, input logic [3:0] tag);
    exp_t e;
    e = '0;
    e.tag = tag;
    if (chain) begin
      logic [128:0]        s;
      logic signed [129:0] sr;
      s  = op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      sr = op ? ($signed({{2{a[127]}}, a}) - $signed({{2{b[127]}}, b}))
              : ($signed({{2{a[127]}}, a}) + $signed({{2{b[127]}}, b}));
      e.r = s[127:0];
      e.n = {4{e.r[127]}};
      e.z = {4{e.r == '0}};
      e.c = {4{op ? (a < b) : s[128]}};
      e.v = {4{sr[128] != sr[127]}};
    end else begin
      for (int i = 0; i < 4; i++) begin
        longint ua, ub, us, sa, sb, ss;
        ua = longint'(a[i*32 +: 32]);
        ub = longint'(b[i*32 +: 32]);
        sa = longint'($signed(a[i*32 +: 32]));
        sb = longint'($signed(b[i*32 +: 32]));
        us = op ? ua - ub : ua + ub;
        ss = op ? sa - sb : sa + sb;
        e.r[i*32 +: 32] = us[31:0];
        e.n[i] = us[31];
        e.z[i] = (us[31:0] == 32'd0);
        e.c[i] = op ? (ua < ub) : (us > 64'sh0FFFFFFFF);
        e.v[i] = (ss > 64'sh7FFFFFFF) || (ss < -64'sh80000000);
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: sample away from the rising edge; the queue front is what S2 must present.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got tag %0d with empty queue", out_tag);
        end else begin
          if ({out_r, out_n, out_z, out_c, out_v, out_tag} !== q[0]) begin
            failures++;
            $display("FAIL sb_result: got r=%h n=%b z=%b c=%b v=%b tag=%0d expected r=%h n=%b z=%b c=%b v=%b tag=%0d",
                     out_r, out_n, out_z, out_c, out_v, out_tag,
                     q[0].r, q[0].n, q[0].z, q[0].c, q[0].v, q[0].tag);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_op, in_chain, in_tag));
    end
  end

  task automatic send(input logic [127:0] a, input logic [127:0] b,
                      input logic op, input logic chain, input logic [3:0] tag);
    int n;
    in_a = a; in_b = b; in_op = op; in_chain = chain; in_tag = tag; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        failures++; checks++;
        $display("FAIL send_timeout: tag %0d not accepted, got in_ready=%b expected 1", tag, in_ready);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input logic [3:0] tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid && out_tag == tag) return;
    end
    failures++; checks++;
    $display("FAIL wait_out: tag %0d never appeared, got out_valid=%b expected 1", tag, out_valid);
  endtask

  task automatic check_flags(input string name, input logic [127:0] r,
                             input logic [3:0] n, input logic [3:0] z,
                             input logic [3:0] c, input logic [3:0] v);
    chk({name, "_r"}, out_r, r);
    chk({name, "_nzcv"}, {out_n, out_z, out_c, out_v}, {n, z, c, v});
  endtask

  initial begin
    exp_t m;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sticky", v_sticky, 0);
    chk("rst_out_r_tag", {out_r, out_tag}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    m = model({32'h7FFFFFFF, 32'd1, 32'd10, 32'd30}, {32'hFFFFFFFF, 32'd1, 32'd30, 32'd10}, 1, 0, 1);
    chk("model_pin_sub", {m.r, m.n, m.z, m.c, m.v},
        {128'h80000000_00000000_FFFFFFEC_00000014, 4'b1010, 4'b0100, 4'b1010, 4'b1000});
    m = model(128'hFFFFFFFF, 128'd1, 0, 1, 0);
    chk("model_pin_chain", {m.r, m.n, m.z, m.c, m.v}, {128'h1_00000000, 16'h0});

    send({32'h7FFFFFFF, 32'd1, 32'd10, 32'd30}, {32'hFFFFFFFF, 32'd1, 32'd30, 32'd10}, 1, 0, 1);
    wait_out(1);
    check_flags("lane_sub", 128'h80000000_00000000_FFFFFFEC_00000014, 4'b1010, 4'b0100, 4'b1010, 4'b1000);
    @(posedge clk); #1;
    chk("sticky_set", v_sticky, 1);
    clr_sticky = 1'b1;
    @(posedge clk); #1 clr_sticky = 1'b0;
    chk("sticky_clear", v_sticky, 0);

    send(128'hFFFFFFFF, 128'd1, 0, 1, 2);
    wait_out(2);
    check_flags("chain_add", 128'h00000000_00000000_00000001_00000000, 0, 0, 0, 0);
    @(posedge clk); #1;
    send(128'd0, 128'd1, 1, 1, 3);
    wait_out(3);
    check_flags("chain_sub", {128{1'b1}}, 4'hF, 0, 4'hF, 0);
    @(posedge clk); #1;
    chk("sticky_no_v", v_sticky, 0);

    send({32'd5, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF}, {32'd3, 32'h80000000, 32'd1, 32'd1}, 0, 0, 4);
    wait_out(4);
    check_flags("lane_add", {32'd8, 32'd0, 32'h80000000, 32'd0}, 4'b0010, 4'b0101, 4'b0101, 4'b0110);
    @(posedge clk); #1 clr_sticky = 1'b1;
    @(posedge clk); #1 clr_sticky = 1'b0;

    // Backpressure: two held in the pipe, third refused until the consumer drains.
    out_ready = 1'b0;
    send({4{32'h11111111}}, {4{32'h01010101}}, 0, 0, 1);
    send({4{32'h22222222}}, {4{32'h02020202}}, 1, 0, 2);
    in_a = {4{32'h33333333}}; in_b = {4{32'h03030303}}; in_op = 0; in_chain = 1; in_tag = 3;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out", {out_valid, out_tag}, {1'b1, 4'd1});
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_tag1", {out_valid, out_tag, in_ready}, {1'b1, 4'd1, 1'b1});
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_tag2", {out_valid, out_tag}, {1'b1, 4'd2});
    @(negedge clk);
    chk("bp_tag3", {out_valid, out_tag}, {1'b1, 4'd3});
    @(posedge clk); #1;

    // Sticky: clear coincident with a V result loading into S2.
    send({4{32'h7FFFFFFF}}, {4{32'h00000001}}, 0, 0, 5);
    clr_sticky = 1'b1;
    @(posedge clk); #1 clr_sticky = 1'b0;
    chk("sticky_set_wins", v_sticky, 1);
    @(posedge clk); #1;

    // Mixed stream under random consumer stalls.
    busy = 1'b1;
    fork
      begin
        send({32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h1}, {32'h1, 32'h0, 32'hFFFFFFFF, 32'h2}, 1, 0, 6);
        send({4{32'hFFFFFFFF}}, 128'd1, 0, 1, 7);
        send({32'h80000000, 96'h0}, 128'd1, 1, 1, 8);
        send({32'h7FFFFFFF, {3{32'hFFFFFFFF}}}, 128'd1, 0, 1, 9);
        for (int i = 0; i < 8; i++)
          send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(10 + i));
        busy = 1'b0;
      end
      begin
        while (busy) begin
          @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    #1 chk("drain_empty", 32'(q.size()), 0);

    // Reset mid-stream with two transactions in flight and sticky set.
    out_ready = 1'b0;
    send({4{32'h7FFFFFFF}}, {4{32'h00000001}}, 0, 0, 1);
    send({4{32'h00000004}}, {4{32'h00000002}}, 0, 0, 2);
    @(posedge clk); #1;
    chk("pre_rst_state", {out_valid, in_ready, v_sticky}, 3'b101);
    rst_n = 1'b0;
    clr_sticky = 1'b1;
    #1;
    chk("mid_rst_state", {out_valid, in_ready, v_sticky}, 3'b010);
    q.delete();
    #1 rst_n = 1'b1;
    clr_sticky = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    send(128'd7, 128'd9, 1, 0, 6);
    wait_out(6);
    chk("post_rst_result", out_r, {32'd0, 32'd0, 32'd0, 32'hFFFFFFFE});
    @(posedge clk); #1;
    chk("final_empty", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
